// File: rtl/ternary_mul_seq.sv
// ternary_mul_seq: sequential unsigned ternary multiplier.
// Two N-trit operands (2 bits per trit, 00/01/10; 11 is illegal) are accepted
// over a ready/valid handshake and multiplied by trit-serial shift-and-add.
// A single (N+1)-trit ternary adder is reused once per multiplier digit unit,
// so the 2N-trit product needs no combinational multiplier array.
module ternary_mul_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inValid,
  output logic           inReady,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           outValid,
  input  logic           outReady,
  output logic [4*N-1:0] product,
  output logic           err
);

  // Partial-product register holds 2N+1 trits: hi = top N+1 trits, lo = bottom N.
  localparam int PW = 2 * (2 * N + 1);
  localparam int HW = 2 * (N + 1);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [2*N-1:0]  m;
  logic [PW-1:0]   p;
  logic [1:0]      adds_left;
  logic [CW-1:0]   cnt;
  logic            err_reg;
  logic            bad_operand;
  logic [HW-1:0]   hi_sum;

  // Ternary addition of two (N+1)-trit values, carry-in 0, carry-out dropped.
  // Each digit sum is 0..5; a sum of 3 or more emits digit (sum-3) and carry 1.
  function automatic logic [HW-1:0] tern_add(input logic [HW-1:0] x,
                                             input logic [HW-1:0] y);
    logic [HW-1:0] r;
    logic [2:0]    s;
    logic [2:0]    d;
    logic          c;
    // NOTE: blocking assignments are correct inside functions and always_comb;
    // they model a chain of combinational values evaluated in order.
    r = '0;
    c = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      s = {1'b0, x[2*i+:2]} + {1'b0, y[2*i+:2]} + {2'b00, c};
      d = s - 3'd3;
      if (s >= 3'd3) begin
        r[2*i+:2] = d[1:0];
        c         = 1'b1;
      end else begin
        r[2*i+:2] = s[1:0];
        c         = 1'b0;
      end
    end
    return r;
  endfunction

  // True when any trit of an N-trit word uses the illegal 11 code.
  function automatic logic has_illegal(input logic [2*N-1:0] v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[2*i+:2] == 2'b11) found = 1'b1;
    end
    return found;
  endfunction

  // Operand legality and the shared adder output, both combinational.
  always_comb begin
    bad_operand = has_illegal(m) | has_illegal(p[2*N-1:0]);
    hi_sum      = tern_add(p[PW-1:2*N], {2'b00, m});
  end

  // State register; reset aborts any operation immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    next_state = state;
    inReady    = 1'b0;
    outValid   = 1'b0;
    product    = '0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) next_state = CHECK;
      end
      CHECK: begin
        if (bad_operand)          next_state = DONE;
        else if (p[1:0] != 2'b00) next_state = ADD;
        else                      next_state = SHIFT;
      end
      ADD: begin
        // The add performed in this cycle is the last one for this digit.
        if (adds_left == 2'd1) next_state = SHIFT;
      end
      SHIFT: begin
        // Digit about to become lo[0] after this shift is the current trit 1.
        if (cnt == CW'(N - 1))    next_state = DONE;
        else if (p[3:2] != 2'b00) next_state = ADD;
        else                      next_state = SHIFT;
      end
      DONE: begin
        outValid = 1'b1;
        product  = p[4*N-1:0];
        err      = err_reg;
        if (outReady) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, repeated adds into hi, and trit-serial shifts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m         <= '0;
      p         <= '0;
      adds_left <= '0;
      cnt       <= '0;
      err_reg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inValid) begin
            m   <= a;
            p   <= {{HW{1'b0}}, b};
            cnt <= '0;
          end
        end
        CHECK: begin
          if (bad_operand) begin
            err_reg <= 1'b1;
            p       <= '0;
          end else begin
            adds_left <= p[1:0];
          end
        end
        ADD: begin
          // hi < 3^N before the first add, so hi + 2M always fits N+1 trits.
          p[PW-1:2*N] <= hi_sum;
          adds_left   <= adds_left - 2'd1;
        end
        SHIFT: begin
          p         <= {2'b00, p[PW-1:2]};
          cnt       <= cnt + CW'(1);
          adds_left <= p[3:2];
        end
        DONE: begin
          if (outReady) err_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_mul_seq.sv
// tb_ternary_mul_seq: directed and random checks of ternary_mul_seq at
// N = 1, 2, 3 and 4, covering reset, latency, product, err and backpressure.
module tb_ternary_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a_r = '0;
  logic [7:0]  b_r = '0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [3:0]  out_valid;
  logic [3:0]  err_v;
  logic [3:0]  p1;
  logic [7:0]  p2;
  logic [11:0] p3;
  logic [15:0] p4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ternary_mul_seq #(.N(1)) u_n1 (
    .clk(clk), .rst(rst), .inValid(in_valid[0]), .inReady(in_ready[0]),
    .a(a_r[1:0]), .b(b_r[1:0]), .outValid(out_valid[0]),
    .outReady(out_ready), .product(p1), .err(err_v[0])
  );
  ternary_mul_seq #(.N(2)) u_n2 (
    .clk(clk), .rst(rst), .inValid(in_valid[1]), .inReady(in_ready[1]),
    .a(a_r[3:0]), .b(b_r[3:0]), .outValid(out_valid[1]),
    .outReady(out_ready), .product(p2), .err(err_v[1])
  );
  ternary_mul_seq #(.N(3)) u_n3 (
    .clk(clk), .rst(rst), .inValid(in_valid[2]), .inReady(in_ready[2]),
    .a(a_r[5:0]), .b(b_r[5:0]), .outValid(out_valid[2]),
    .outReady(out_ready), .product(p3), .err(err_v[2])
  );
  ternary_mul_seq #(.N(4)) u_n4 (
    .clk(clk), .rst(rst), .inValid(in_valid[3]), .inReady(in_ready[3]),
    .a(a_r[7:0]), .b(b_r[7:0]), .outValid(out_valid[3]),
    .outReady(out_ready), .product(p4), .err(err_v[3])
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Product of instance k (N = k+1), zero-extended.
  function automatic logic [31:0] prod_of(input int k);
    case (k)
      0:       return {28'b0, p1};
      1:       return {24'b0, p2};
      2:       return {20'b0, p3};
      default: return {16'b0, p4};
    endcase
  endfunction

  // Integer to n-trit encoding.
  function automatic logic [31:0] enc(input int v, input int n);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int i = 0; i < n; i++) begin
      r[2*i+:2] = 2'(t % 3);
      t         = t / 3;
    end
    return r;
  endfunction

  function automatic int digit_sum(input int v, input int n);
    int s;
    int t;
    s = 0;
    t = v;
    for (int i = 0; i < n; i++) begin
      s = s + (t % 3);
      t = t / 3;
    end
    return s;
  endfunction

  // Present one request to instance k and count edges until outValid.
  task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                       output int lat);
    int w;
    w = 0;
    while (!in_ready[k] && w < 50) begin
      @(posedge clk); #1; w++;
    end
    check("in_ready_before_issue", 32'(in_ready[k]), 32'd1);
    a_r         = av;
    b_r         = bv;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    // Operands are garbage from here on; the block must ignore them.
    a_r = '1;
    b_r = '1;
    lat = 0;
    while (!out_valid[k] && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Accept the held result and confirm IDLE follows one cycle later.
  task automatic release_result(input int k);
    check("in_ready_while_done", 32'(in_ready[k]), 32'd0);
    out_ready = 1'b1;
    #2;
    check("in_ready_same_cycle_as_out_ready", 32'(in_ready[k]), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_accept", 32'(in_ready[k]), 32'd1);
    check("out_valid_after_accept", 32'(out_valid[k]), 32'd0);
  endtask

  initial begin
    int          lat;
    int          k;
    int          n;
    int          lim;
    int          av;
    int          bv;
    logic [31:0] ea;
    logic [31:0] eb;

    // Reset values on every instance.
    #3;
    for (int i = 0; i < 4; i++) begin
      check("reset_in_ready", 32'(in_ready[i]), 32'd1);
      check("reset_out_valid", 32'(out_valid[i]), 32'd0);
      check("reset_product", prod_of(i), 32'd0);
      check("reset_err", 32'(err_v[i]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-run, N=2, a=b=22 (8): abort while in ADD.
    a_r = 8'h0A; b_r = 8'h0A; in_valid[1] = 1'b1;
    @(posedge clk); #1;            // now in CHECK
    in_valid[1] = 1'b0;
    @(posedge clk); #1;            // now in ADD (lo[0] = 2)
    check("pre_reset_in_ready", 32'(in_ready[1]), 32'd0);
    rst = 1'b1;
    #1;
    check("midrun_reset_in_ready", 32'(in_ready[1]), 32'd1);
    check("midrun_reset_out_valid", 32'(out_valid[1]), 32'd0);
    check("midrun_reset_product", prod_of(1), 32'd0);
    check("midrun_reset_err", 32'(err_v[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // 8*8 = 64 = 2101 (10 01 00 01); latency 1 + (2+2) + 2 = 7.
    issue(1, 8'h0A, 8'h0A, lat);
    check("reissue_product", prod_of(1), 32'h91);
    check("reissue_latency", 32'(lat), 32'd7);
    check("reissue_err", 32'(err_v[1]), 32'd0);
    release_result(1);

    // Zero multiplier, N=4: a=2222, b=0; latency 1+0+4 = 5.
    issue(3, 8'hAA, 8'h00, lat);
    check("zero_mul_product", prod_of(3), 32'd0);
    check("zero_mul_latency", 32'(lat), 32'd5);
    check("zero_mul_err", 32'(err_v[3]), 32'd0);
    release_result(3);

    // Maximum operands, N=4: 80*80 = 6400 = 22210001; latency 1+8+4 = 13.
    issue(3, 8'hAA, 8'hAA, lat);
    check("max_product", prod_of(3), 32'hA901);
    check("max_latency", 32'(lat), 32'd13);
    check("max_err", 32'(err_v[3]), 32'd0);
    release_result(3);

    // Illegal trit 2 in b: result well within two cycles, err=1, product=0.
    issue(3, 8'h01, 8'h30, lat);
    check("illegal_latency_within_2", 32'(lat <= 2), 32'd1);
    check("illegal_err", 32'(err_v[3]), 32'd1);
    check("illegal_product", prod_of(3), 32'd0);
    release_result(3);

    // Illegal trit in a on the N=3 instance.
    issue(2, 8'h0C, 8'h01, lat);
    check("illegal_a_err", 32'(err_v[2]), 32'd1);
    check("illegal_a_product", prod_of(2), 32'd0);
    release_result(2);

    // Next legal request after an error: 1*2 = 2, latency 1+2+4 = 7, err=0.
    issue(3, 8'h01, 8'h02, lat);
    check("after_err_product", prod_of(3), 32'h2);
    check("after_err_latency", 32'(lat), 32'd7);
    check("after_err_err", 32'(err_v[3]), 32'd0);
    release_result(3);

    // Backpressure: hold the result 10 cycles; it must stay put.
    issue(3, 8'h01, 8'h02, lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_product", prod_of(3), 32'h2);
      check("bp_out_valid", 32'(out_valid[3]), 32'd1);
      check("bp_in_ready", 32'(in_ready[3]), 32'd0);
      @(posedge clk); #1;
    end
    release_result(3);

    // Random legal operands on N = 1, 3, 4 against the integer product.
    for (int rep = 0; rep < 1000; rep++) begin
      k   = (rep % 3 == 0) ? 0 : ((rep % 3 == 1) ? 2 : 3);
      n   = k + 1;
      lim = (n == 1) ? 3 : ((n == 3) ? 27 : 81);
      av  = int'($urandom_range(lim - 1, 0));
      bv  = int'($urandom_range(lim - 1, 0));
      ea  = enc(av, n);
      eb  = enc(bv, n);
      issue(k, ea[7:0], eb[7:0], lat);
      check("rand_product", prod_of(k), enc(av * bv, 2 * n));
      check("rand_latency", 32'(lat), 32'(1 + digit_sum(bv, n) + n));
      check("rand_err", 32'(err_v[k]), 32'd0);
      release_result(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
